// File: rtl/chunked_seq_adder_pkg.sv
// Shared types and default sizing for the chunked sequential adder.
package chunked_seq_adder_pkg;

    // Controller states: wait for a request, add one slice per clock, flag completion.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Default sizing used by the datapath ALU.
    localparam int DEF_WIDTH = 32;
    localparam int DEF_CHUNK = 8;

endpackage : chunked_seq_adder_pkg

// File: rtl/chunked_seq_adder_if.sv
// Request/result bundle between a requester and the chunked sequential adder.
interface chunked_seq_adder_if #(
    parameter int WIDTH = 32
) ();

    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;
    logic             zero;

    // Requester side: issues operations and watches status/results.
    modport master (
        output start, sub, a, b, c_in,
        input  busy, done, sum, c_out, ovf, zero
    );

    // Adder side: accepts operations and presents results.
    modport slave (
        input  start, sub, a, b, c_in,
        output busy, done, sum, c_out, ovf, zero
    );

endinterface : chunked_seq_adder_if

// File: rtl/chunked_seq_adder_chunk_adder.sv
// CHUNK-bit combinational ripple adder; also exposes the carry into its top
// bit so the caller can form signed overflow on the last slice.
module chunked_seq_adder_chunk_adder #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             cout_o,
    output logic             c_msb_in_o
);

    logic [CHUNK:0] carry;

    assign carry[0] = cin_i;

    // One full adder per bit, rippling the carry upward.
    for (genvar gi = 0; gi < CHUNK; gi++) begin : g_bit
        assign sum_o[gi]    = a_i[gi] ^ b_i[gi] ^ carry[gi];
        assign carry[gi+1]  = (a_i[gi] & b_i[gi]) | (carry[gi] & (a_i[gi] ^ b_i[gi]));
    end

    assign cout_o     = carry[CHUNK];
    assign c_msb_in_o = carry[CHUNK-1];

endmodule : chunked_seq_adder_chunk_adder

// File: rtl/chunked_seq_adder.sv
// Multi-cycle two's-complement adder/subtractor: a WIDTH-bit operation is
// processed CHUNK bits per clock with the inter-slice carry held in a register.
module chunked_seq_adder
    import chunked_seq_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    chunked_seq_adder_if.slave bus
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    // Refuse to elaborate with a slice size that does not tile the word.
    if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("chunked_seq_adder: WIDTH must be a positive multiple of CHUNK");
    end

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               c_out_q, c_out_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;

    logic [CHUNK-1:0]   a_slice;
    logic [CHUNK-1:0]   b_slice;
    logic [CHUNK-1:0]   s_slice;
    logic               co_slice;
    logic               cmsb_slice;

    // Select the operand slice addressed by the current index.
    assign a_slice = a_q[idx_q*CHUNK +: CHUNK];
    assign b_slice = b_q[idx_q*CHUNK +: CHUNK];

    chunked_seq_adder_chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .a_i        (a_slice),
        .b_i        (b_slice),
        .cin_i      (carry_q),
        .sum_o      (s_slice),
        .cout_o     (co_slice),
        .c_msb_in_o (cmsb_slice)
    );

    // Next-state logic: latch operands on accept, fold in one slice per RUN cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    // Subtraction is a + ~b + 1, so invert B once here.
                    a_d     = bus.a;
                    b_d     = bus.b ^ {WIDTH{bus.sub}};
                    carry_d = bus.sub | bus.c_in;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q*CHUNK +: CHUNK] = s_slice;
                carry_d = co_slice;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    c_out_d = co_slice;
                    ovf_d   = cmsb_slice ^ co_slice;
                    zero_d  = (sum_d == '0);
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                // Requests arriving here are dropped; the requester retries in IDLE.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.busy  = (state_q == RUN);
    assign bus.done  = (state_q == DONE);
    assign bus.sum   = sum_q;
    assign bus.c_out = c_out_q;
    assign bus.ovf   = ovf_q;
    assign bus.zero  = zero_q;

endmodule : chunked_seq_adder
